// File: rtl/scan_line_decoder_if.sv
// Control/status bundle for scan_line_decoder: master drives en/mode/load/num,
// slave returns the registered line outputs y, the current index and the wrap pulse.
interface scan_line_decoder_if #(
  parameter int unsigned SEL_W = 3,
  parameter int unsigned N_OUT = 8
);
  logic             en;
  logic             mode;
  logic             load;
  logic [SEL_W-1:0] num;
  logic [N_OUT-1:0] y;
  logic [SEL_W-1:0] cur;
  logic             wrap;

  modport master (output en, mode, load, num, input y, cur, wrap);
  modport slave  (input en, mode, load, num, output y, cur, wrap);
endinterface

// File: rtl/scan_line_decoder.sv
// Registered binary-to-one-hot line decoder with direct and prescaled scan modes.
// Optional macro SCAN_LINE_DECODER_BLANK_EN blanks y on the last clock of each scan step.
module scan_line_decoder #(
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned N_OUT      = 8,
  parameter int unsigned PRESCALE   = 1000,
  parameter int unsigned ACTIVE_LOW = 0
) (
  input  logic clk,
  input  logic n_reset,
  scan_line_decoder_if.slave bus
);
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned CW = SEL_W + 1;
  localparam logic [PW-1:0]    P_LAST = PW'(PRESCALE - 1);
  localparam logic [SEL_W-1:0] I_LAST = SEL_W'(N_OUT - 1);
  localparam logic [N_OUT-1:0] IDLE   = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [SEL_W-1:0] index_q, index_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             mode_q, mode_d;
  logic [N_OUT-1:0] y_q, y_d;
  logic             wrap_q, wrap_d;
  logic             num_ok;

  // Next-state: loads, scan stepping and output decode of the next index.
  always_comb begin
    index_d = index_q;
    presc_d = presc_q;
    mode_d  = mode_q;
    wrap_d  = 1'b0;
    y_d     = IDLE;
    num_ok  = CW'(bus.num) < CW'(N_OUT);
    if (bus.en) begin
      mode_d = bus.mode;
      if (bus.load && num_ok) begin
        index_d = bus.num;
      end
      // A load, a mode change or direct mode all restart the step timer.
      if (!bus.mode || (bus.mode != mode_q) || bus.load) begin
        presc_d = '0;
      end else if (presc_q == P_LAST) begin
        presc_d = '0;
        index_d = (index_q == I_LAST) ? '0 : index_q + SEL_W'(1);
        wrap_d  = (index_q == I_LAST);
      end else begin
        presc_d = presc_q + PW'(1);
      end
      y_d = (N_OUT'(1) << index_d) ^ IDLE;
`ifdef SCAN_LINE_DECODER_BLANK_EN
      if (bus.mode && (presc_d == P_LAST)) begin
        y_d = IDLE;
      end
`else
`endif
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      index_q <= '0;
      presc_q <= '0;
      mode_q  <= 1'b0;
      y_q     <= IDLE;
      wrap_q  <= 1'b0;
    end else begin
      index_q <= index_d;
      presc_q <= presc_d;
      mode_q  <= mode_d;
      y_q     <= y_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.y    = y_q;
  assign bus.cur  = index_q;
  assign bus.wrap = wrap_q;
endmodule

// File: doc/scan_line_decoder.md
Name: scan_line_decoder

Overview:
- Registered, parametrised binary-to-one-hot line decoder; generalises the fixed 3-to-8 combinational decoder to SEL_W select bits and N_OUT outputs.
- Direct mode: decodes a loaded index.
- Scan mode: walks the one-hot output through all N_OUT lines on a prescaled tick. Used for multiplexed 7-segment digit select and LED column scanning on the CDEC board.

Parameters:
- SEL_W, 3, width of index/select, >= 1.
- N_OUT, 8, number of output lines, 2 <= N_OUT <= 2**SEL_W.
- PRESCALE, 1000, clk cycles per scan step, >= 2.
- ACTIVE_LOW, 0, 1 = outputs asserted low (inactive level all ones).

Ports:
- clk  in  1  system clock, rising edge.
- n_reset  in  1  asynchronous active-low reset.
- en  in  1  output enable; 0 forces all outputs inactive and freezes state.
- mode  in  1  0 = direct, 1 = scan.
- load  in  1  load strobe for num.
- num  in  SEL_W  index to load.
- y  out  N_OUT  one-hot (or one-cold if ACTIVE_LOW) line outputs, registered.
- cur  out  SEL_W  current index, registered.
- wrap  out  1  one-cycle pulse when scan index wraps N_OUT-1 -> 0.

Behaviour:
- Reset (n_reset low, async): index = 0; prescaler = 0; y = all inactive; wrap = 0. First active edge after release behaves as a normal cycle.
- Clock and reset: one clock (clk); reset is asynchronous and active-low (n_reset).
- All outputs are registered; no combinational path from inputs to y, cur or wrap.
- y is the decode of the next index, registered on the same edge. Latency from load, or from a scan step, to y is 1 cycle.
- en = 0:
  - y goes all inactive on the next edge; wrap = 0.
  - index, prescaler and cur hold; load is ignored.
  - On en returning to 1, y shows decode(index) on the next edge.
- Direct mode (mode = 0):
  - load & en & (num < N_OUT): index <= num.
  - num >= N_OUT: load ignored, index holds.
  - Prescaler held at 0; wrap = 0.
- Scan mode (mode = 1, en = 1):
  - Prescaler counts 0..PRESCALE-1.
  - At the terminal count: prescaler -> 0 and index advances by 1, wrapping N_OUT-1 -> 0 (not 2**SEL_W-1).
  - wrap = 1 for exactly the cycle following the wrap edge.
- load in scan mode: index <= num (if valid) and prescaler <= 0. load wins over a simultaneous terminal-count step, and no wrap pulse is produced.
- Mode change, either direction: prescaler cleared on that edge; index held.
- Prescaler width: clog2(PRESCALE).
- index/cur never exceeds N_OUT-1.
- Reset asserted mid-scan: immediate return to the reset values, with no wrap pulse.
- ACTIVE_LOW = 1: y is the bitwise inverse of the active-high value, including the inactive all-ones state.

Optional Feature:
- Macro: SCAN_LINE_DECODER_BLANK_EN.
- Defined: in scan mode, y is all inactive for the last clock of every step (prescaler == PRESCALE-1), giving an anti-ghosting gap between digits. cur and wrap are unaffected. Direct mode is unaffected.
- Undefined: no blanking; y is continuously one-hot while en = 1.

Test Plan:
- Reset and defaults: assert n_reset low mid-run with SEL_W=3, N_OUT=8 -> y = 8'h00, cur = 0, wrap = 0 immediately. Release, mode = 0, en = 1 -> y = 8'h01 after 1 cycle.
- Direct decode: load num = 0..7 one per cycle -> y = 8'h01, 8'h02, ..., 8'h80, each 1 cycle after its load. Then num = 5 with load and en = 0 -> y = 8'h00, cur stays 7.
- Invalid index: N_OUT = 6, cur = 2, load num = 6 or 7 -> cur stays 2, y = 6'b000100.
- Scan wrap: PRESCALE = 4, N_OUT = 6, mode = 1 -> y steps through 000001 .. 100000 every 4 cycles, then back to 000001. wrap is high for exactly 1 cycle per 24 cycles, coincident with the return to 000001.
- Load during scan: load num = 3 on the same edge as a terminal count -> cur = 3, prescaler restarts (next step exactly 4 cycles later), no wrap pulse.
- ACTIVE_LOW = 1 with SCAN_LINE_DECODER_BLANK_EN, PRESCALE = 4:
  - y = 8'hFE for 3 cycles, then 8'hFF for 1 cycle, then 8'hFD.
  - en = 0 gives y = 8'hFF.
